// File: rtl/placar_frota_pkg.sv
// Shared definitions for the naval-battle fleet scoreboard: ship classes,
// scan states and word helpers.
package batalha_pkg;

  localparam int N_SUBMARINO    = 5;
  localparam int N_CRUZADOR     = 2;
  localparam int N_HIDROAVIAO   = 2;
  localparam int N_ENCOURACADO  = 1;
  localparam int N_PORTA_AVIOES = 1;

  localparam int V_SUBMARINO    = 1;
  localparam int V_CRUZADOR     = 2;
  localparam int V_HIDROAVIAO   = 3;
  localparam int V_ENCOURACADO  = 4;
  localparam int V_PORTA_AVIOES = 5;

  // Widest memory word the sunk test can inspect; narrower words are zero-extended.
  localparam int MAX_DATA_W = 128;

  typedef enum logic [1:0] {
    IDLE,
    VARRE,
    DRENA
  } estado_t;

  // Ships are stored in class order, so the index alone determines the value.
  function automatic logic [2:0] valor_navio(input int unsigned idx);
    int unsigned lim;
    lim = N_SUBMARINO;
    if (idx < lim) return 3'(V_SUBMARINO);
    lim += N_CRUZADOR;
    if (idx < lim) return 3'(V_CRUZADOR);
    lim += N_HIDROAVIAO;
    if (idx < lim) return 3'(V_HIDROAVIAO);
    lim += N_ENCOURACADO;
    if (idx < lim) return 3'(V_ENCOURACADO);
    lim += N_PORTA_AVIOES;
    if (idx < lim) return 3'(V_PORTA_AVIOES);
    return 3'd0;
  endfunction

  function automatic logic afundado(input logic [MAX_DATA_W-1:0] word,
                                    input int msb, input int w);
    logic r;
    r = 1'b1;
    for (int i = 0; i < MAX_DATA_W; i++) begin
      if (i <= msb && i > msb - w && word[i]) r = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/placar_frota_if.sv
// Control and memory-port bundle between the game FSM, the coordinate RAMs
// and the fleet scoreboard.
interface placar_frota_if #(
  parameter int NUM_JOGADORES = 2,
  parameter int NUM_NAVIOS    = 11,
  parameter int DATA_W        = 64,
  parameter int PONTOS_W      = 6
);
  localparam int JOG_W  = (NUM_JOGADORES > 1) ? $clog2(NUM_JOGADORES) : 1;
  localparam int ADDR_W = $clog2(NUM_NAVIOS);
  localparam int CNT_W  = $clog2(NUM_NAVIOS + 1);

  logic                              iniciar;
  logic [JOG_W-1:0]                  jogador;
  logic [JOG_W-1:0]                  mem_jogador;
  logic [ADDR_W-1:0]                 mem_addr;
  logic                              mem_rd;
  logic [DATA_W-1:0]                 mem_dado;
  logic                              ocupado;
  logic                              pronto;
  logic [NUM_JOGADORES*CNT_W-1:0]    restantes;
  logic [NUM_JOGADORES*PONTOS_W-1:0] pontos;
  logic [CNT_W-1:0]                  novos_afundados;
  logic [NUM_JOGADORES-1:0]          frota_destruida;

  modport slave (
    input  iniciar, jogador, mem_dado,
    output mem_jogador, mem_addr, mem_rd, ocupado, pronto,
           restantes, pontos, novos_afundados, frota_destruida
  );

  modport master (
    output iniciar, jogador, mem_dado,
    input  mem_jogador, mem_addr, mem_rd, ocupado, pronto,
           restantes, pontos, novos_afundados, frota_destruida
  );
endinterface

// File: rtl/placar_frota.sv
// Fleet scoreboard: scans one player's ship RAM on request and republishes
// remaining ships, points against the fleet and ships sunk since last scan.
module placar_frota
  import batalha_pkg::*;
#(
  parameter int NUM_JOGADORES = 2,
  parameter int NUM_NAVIOS    = 11,
  parameter int DATA_W        = 64,
  parameter int COORD_MSB     = 42,
  parameter int COORD_W       = 40,
  parameter int PONTOS_W      = 6
) (
  input logic clk,
  input logic reset,
  placar_frota_if.slave bus
);

  localparam int JOG_W   = (NUM_JOGADORES > 1) ? $clog2(NUM_JOGADORES) : 1;
  localparam int ADDR_W  = $clog2(NUM_NAVIOS);
  localparam int CNT_W   = $clog2(NUM_NAVIOS + 1);
  localparam int SUM_W   = CNT_W + 3;
  localparam int PTS_MAX = (1 << PONTOS_W) - 1;

  estado_t                           r_estado;
  logic [JOG_W-1:0]                  r_jog;
  logic [ADDR_W-1:0]                 r_addr;
  logic                              r_rd;
  logic [ADDR_W-1:0]                 r_addrD;
  logic                              r_rdD;
  logic [CNT_W-1:0]                  r_afund;
  logic [SUM_W-1:0]                  r_soma;
  logic                              r_ocupado;
  logic                              r_pronto;
  logic [NUM_JOGADORES*CNT_W-1:0]    r_restantes;
  logic [NUM_JOGADORES*PONTOS_W-1:0] r_pontos;
  logic [CNT_W-1:0]                  r_novos;
  logic [NUM_JOGADORES-1:0]          r_frota;

  logic [MAX_DATA_W-1:0] w_dadoExt;
  logic                  w_jogValido;
  logic                  w_conta;
  logic [CNT_W-1:0]      w_afundTot;
  logic [SUM_W-1:0]      w_somaTot;
  logic [CNT_W-1:0]      w_restNovo;
  logic [CNT_W-1:0]      w_restVelho;
  logic [PONTOS_W-1:0]   w_pontosNovo;

  assign w_dadoExt   = MAX_DATA_W'(bus.mem_dado);
  assign w_jogValido = {1'b0, bus.jogador} < (JOG_W + 1)'(NUM_JOGADORES);

  // The word on mem_dado belongs to last cycle's address, hence the delayed qualifier.
  assign w_conta     = r_rdD && afundado(w_dadoExt, COORD_MSB, COORD_W);
  assign w_afundTot  = r_afund + CNT_W'(w_conta);
  assign w_somaTot   = r_soma + (w_conta ? SUM_W'(valor_navio(32'(r_addrD))) : '0);
  assign w_restNovo  = CNT_W'(NUM_NAVIOS) - w_afundTot;
  assign w_restVelho = r_restantes[int'(r_jog)*CNT_W +: CNT_W];

  always_comb begin
    w_pontosNovo = PONTOS_W'(w_somaTot);
    if (32'(w_somaTot) > PTS_MAX) w_pontosNovo = PONTOS_W'(PTS_MAX);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_estado    <= IDLE;
      r_jog       <= '0;
      r_addr      <= '0;
      r_rd        <= 1'b0;
      r_addrD     <= '0;
      r_rdD       <= 1'b0;
      r_afund     <= '0;
      r_soma      <= '0;
      r_ocupado   <= 1'b0;
      r_pronto    <= 1'b0;
      r_restantes <= {NUM_JOGADORES{CNT_W'(NUM_NAVIOS)}};
      r_pontos    <= '0;
      r_novos     <= '0;
      r_frota     <= '0;
    end else begin
      r_pronto <= 1'b0;
      r_addrD  <= r_addr;
      r_rdD    <= r_rd;
      if (w_conta) begin
        r_afund <= w_afundTot;
        r_soma  <= w_somaTot;
      end
      case (r_estado)
        IDLE: begin
          if (bus.iniciar && w_jogValido) begin
            r_jog     <= bus.jogador;
            r_afund   <= '0;
            r_soma    <= '0;
            r_addr    <= '0;
            r_rd      <= 1'b1;
            r_ocupado <= 1'b1;
            r_estado  <= VARRE;
          end
        end
        VARRE: begin
          if (r_addr == ADDR_W'(NUM_NAVIOS - 1)) begin
            r_rd     <= 1'b0;
            r_estado <= DRENA;
          end else begin
            r_addr <= r_addr + 1'b1;
          end
        end
        DRENA: begin
          for (int p = 0; p < NUM_JOGADORES; p++) begin
            if (JOG_W'(p) == r_jog) begin
              r_restantes[p*CNT_W +: CNT_W]       <= w_restNovo;
              r_pontos[p*PONTOS_W +: PONTOS_W]    <= w_pontosNovo;
              r_frota[p]                          <= (w_restNovo == '0);
            end
          end
          // A ship that reappears in RAM must not produce a negative delta.
          r_novos   <= (w_restNovo > w_restVelho) ? '0 : (w_restVelho - w_restNovo);
          r_ocupado <= 1'b0;
          r_pronto  <= 1'b1;
          r_estado  <= IDLE;
        end
        default: r_estado <= IDLE;
      endcase
    end
  end

  assign bus.mem_jogador     = r_jog;
  assign bus.mem_addr        = r_addr;
  assign bus.mem_rd          = r_rd;
  assign bus.ocupado         = r_ocupado;
  assign bus.pronto          = r_pronto;
  assign bus.restantes       = r_restantes;
  assign bus.pontos          = r_pontos;
  assign bus.novos_afundados = r_novos;
  assign bus.frota_destruida = r_frota;

endmodule

// File: tb/tb_placar_frota.sv
// Directed bench for placar_frota: a scan table plus hand sequences for
// overlapping requests, mid-scan reset and points saturation.
module tb_placar_frota;

  localparam logic [63:0] W_AFUNDADO = 64'hFFFF_F800_0000_0007;
  localparam logic [63:0] W_VIVO_LO  = 64'h0000_0000_0000_0008;
  localparam logic [63:0] W_VIVO_HI  = 64'h0000_0400_0000_0000;

  typedef struct {
    int          jog;
    logic [10:0] mask;
    int          expRest0;
    int          expRest1;
    int          expPts0;
    int          expPts1;
    int          expNovos;
    int          expFrota;
  } vetor_t;

  logic clk;
  logic reset;
  logic [63:0] ram  [2][16];
  logic [63:0] ram4 [2][16];
  int nCompared;
  int nMismatched;
  vetor_t tabela [7];

  placar_frota_if bus ();
  placar_frota_if #(.PONTOS_W(4)) bus4 ();

  placar_frota dut (.clk(clk), .reset(reset), .bus(bus.slave));
  placar_frota #(.PONTOS_W(4)) dut4 (.clk(clk), .reset(reset), .bus(bus4.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Coordinate RAM models: one-cycle read latency.
  always @(posedge clk) begin
    if (bus.mem_rd) bus.mem_dado <= ram[bus.mem_jogador][bus.mem_addr];
    if (bus4.mem_rd) bus4.mem_dado <= ram4[bus4.mem_jogador][bus4.mem_addr];
  end

  task automatic checkOutput(input string nome, input longint act, input longint exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", nome, act, exp);
    end
  endtask

  task automatic iniciaVarredura(input bit quatro, input int jog);
    if (quatro) begin
      bus4.jogador = 1'(jog);
      bus4.iniciar = 1'b1;
    end else begin
      bus.jogador = 1'(jog);
      bus.iniciar = 1'b1;
    end
    @(negedge clk);
    bus.iniciar  = 1'b0;
    bus4.iniciar = 1'b0;
  endtask

  task automatic esperaPronto(input bit quatro, output int ciclos);
    ciclos = 1;
    while (!(quatro ? bus4.pronto : bus.pronto) && ciclos < 40) begin
      @(negedge clk);
      ciclos++;
    end
    if (ciclos >= 40) $display("[TB] FAIL timeout waiting for pronto");
  endtask

  task automatic carregaRam(input int jog, input logic [10:0] mask);
    for (int i = 0; i < 11; i++)
      ram[jog][i] = mask[i] ? W_AFUNDADO : ((i % 2 == 1) ? W_VIVO_HI : W_VIVO_LO);
  endtask

  task automatic applyStimulus(input vetor_t v, input int idx);
    int ciclos;
    carregaRam(v.jog, v.mask);
    iniciaVarredura(1'b0, v.jog);
    checkOutput($sformatf("v%0d_ocupado_c1", idx), bus.ocupado, 1);
    esperaPronto(1'b0, ciclos);
    checkOutput($sformatf("v%0d_pronto_ciclo", idx), ciclos, 13);
    checkOutput($sformatf("v%0d_ocupado_pronto", idx), bus.ocupado, 0);
    checkOutput($sformatf("v%0d_rest0", idx), bus.restantes[3:0], v.expRest0);
    checkOutput($sformatf("v%0d_rest1", idx), bus.restantes[7:4], v.expRest1);
    checkOutput($sformatf("v%0d_pts0", idx), bus.pontos[5:0], v.expPts0);
    checkOutput($sformatf("v%0d_pts1", idx), bus.pontos[11:6], v.expPts1);
    checkOutput($sformatf("v%0d_novos", idx), bus.novos_afundados, v.expNovos);
    checkOutput($sformatf("v%0d_frota", idx), bus.frota_destruida, v.expFrota);
  endtask

  initial begin
    int ciclos;
    int nPronto;
    nCompared   = 0;
    nMismatched = 0;
    bus.iniciar  = 1'b0;
    bus.jogador  = '0;
    bus.mem_dado = '0;
    bus4.iniciar  = 1'b0;
    bus4.jogador  = '0;
    bus4.mem_dado = '0;
    for (int p = 0; p < 2; p++)
      for (int i = 0; i < 16; i++) begin
        ram[p][i]  = W_VIVO_LO;
        ram4[p][i] = '0;
      end

    //               jog  mask    r0  r1  p0  p1  nov frota
    tabela[0] = '{0, 11'h7FF,  0, 11, 24,  0, 11, 1};
    tabela[1] = '{1, 11'h421,  0,  8, 24,  8,  3, 1};
    tabela[2] = '{1, 11'h4A1,  0,  7, 24, 11,  1, 1};
    tabela[3] = '{0, 11'h000, 11,  7,  0, 11,  0, 0};
    tabela[4] = '{1, 11'h7FF, 11,  0,  0, 24,  7, 2};
    tabela[5] = '{1, 11'h7FF, 11,  0,  0, 24,  0, 2};
    tabela[6] = '{0, 11'h202,  9,  0,  5, 24,  2, 2};

    reset = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("rst_ocupado", bus.ocupado, 0);
    checkOutput("rst_pronto", bus.pronto, 0);
    checkOutput("rst_mem_rd", bus.mem_rd, 0);
    checkOutput("rst_mem_addr", bus.mem_addr, 0);
    checkOutput("rst_mem_jogador", bus.mem_jogador, 0);
    checkOutput("rst_restantes", bus.restantes, 8'hBB);
    checkOutput("rst_pontos", bus.pontos, 0);
    checkOutput("rst_novos", bus.novos_afundados, 0);
    checkOutput("rst_frota", bus.frota_destruida, 0);

    for (int i = 0; i < 7; i++) applyStimulus(tabela[i], i);

    // Requests at cycles 3 and 12 of a running scan must be dropped.
    iniciaVarredura(1'b0, 0);
    ciclos = 1;
    while (!bus.pronto && ciclos < 40) begin
      @(negedge clk);
      ciclos++;
      bus.jogador = 1'b1;
      bus.iniciar = (ciclos == 3 || ciclos == 12);
    end
    bus.iniciar = 1'b0;
    checkOutput("busy_pronto_ciclo", ciclos, 13);
    nPronto = 1;
    repeat (20) begin
      @(negedge clk);
      if (bus.pronto) nPronto++;
    end
    checkOutput("busy_pronto_count", nPronto, 1);

    // Back-to-back: the second request lands in the pronto cycle.
    carregaRam(0, 11'h7FF);
    iniciaVarredura(1'b0, 1);
    esperaPronto(1'b0, ciclos);
    checkOutput("b2b_first_ciclo", ciclos, 13);
    iniciaVarredura(1'b0, 0);
    checkOutput("b2b_mem_jogador", bus.mem_jogador, 0);
    esperaPronto(1'b0, ciclos);
    checkOutput("b2b_second_ciclo", ciclos, 13);
    checkOutput("b2b_rest0", bus.restantes[3:0], 0);
    checkOutput("b2b_pts0", bus.pontos[5:0], 24);
    checkOutput("b2b_novos", bus.novos_afundados, 9);
    checkOutput("b2b_frota", bus.frota_destruida, 3);

    // Reset during cycle 6 aborts the scan with no pronto.
    iniciaVarredura(1'b0, 1);
    for (int c = 2; c <= 6; c++) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    nPronto = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.pronto) nPronto++;
    end
    checkOutput("midrst_pronto_count", nPronto, 0);
    checkOutput("midrst_mem_rd", bus.mem_rd, 0);
    checkOutput("midrst_ocupado", bus.ocupado, 0);
    checkOutput("midrst_restantes", bus.restantes, 8'hBB);
    checkOutput("midrst_pontos", bus.pontos, 0);
    checkOutput("midrst_frota", bus.frota_destruida, 0);

    // Narrow points counter: 24 points must clamp to 15.
    iniciaVarredura(1'b1, 1);
    esperaPronto(1'b1, ciclos);
    checkOutput("sat_pronto_ciclo", ciclos, 13);
    checkOutput("sat_pts1", bus4.pontos[7:4], 15);
    checkOutput("sat_pts0", bus4.pontos[3:0], 0);
    checkOutput("sat_rest1", bus4.restantes[7:4], 0);
    checkOutput("sat_novos", bus4.novos_afundados, 11);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
